// File: rtl/rf_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rf_arb_pkg                                                            |
// | Shared defaults and types for the register-file write arbiter.        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package rf_arb_pkg;
  localparam int RF_ADDR_W  = 3;
  localparam int RF_DATA_W  = 16;
  localparam int RF_NUM_REQ = 3;

  typedef logic [1:0] rf_req_id_t;
endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter                                                            |
// | Round-robin pointer and single-winner grant pick for up to 4 ports.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module rr_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NUM_REQ = RF_NUM_REQ
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               stall,
  output logic [NUM_REQ-1:0] req_ready,
  output logic               accept,
  output rf_req_id_t         win_id
);

  rf_req_id_t r_ptr;
  logic       w_found;
  rf_req_id_t w_win;

  // Two passes: requesters at or above the pointer first, then the wrapped ones below it.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req_valid[i] && (rf_req_id_t'(i) >= r_ptr)) begin
        w_found = 1'b1;
        w_win   = rf_req_id_t'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req_valid[i]) begin
        w_found = 1'b1;
        w_win   = rf_req_id_t'(i);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = w_found && (w_win == rf_req_id_t'(i)) && !stall && !reset;
    end
  end

  assign accept = |req_ready;
  assign win_id = w_win;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (accept) begin
      r_ptr <= (w_win == rf_req_id_t'(NUM_REQ - 1)) ? '0 : w_win + 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_write_arbiter                                                 |
// | Round-robin write-port arbiter with a one-cycle registered RF write.  |
// | Optional feature macro: RF_ARB_PERF_EN (adds conflict_cnt).           |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module regfile_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NUM_REQ = RF_NUM_REQ,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int DATA_W  = RF_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      stall,
  output logic                      rf_write_n,
  output logic [ADDR_W-1:0]         rf_addr,
  output logic [DATA_W-1:0]         rf_data,
  output logic [2**ADDR_W-1:0]      rf_busy,
  output logic [1:0]                grant_id
`ifdef RF_ARB_PERF_EN
  ,
  output logic [15:0]               conflict_cnt
`endif
);

  logic              w_accept;
  rf_req_id_t        w_win;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;

  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  rf_req_id_t        r_gid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .stall     (stall),
    .req_ready (req_ready),
    .accept    (w_accept),
    .win_id    (w_win)
  );

  always_comb begin
    w_addr = '0;
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == rf_req_id_t'(i)) begin
        w_addr = req_addr[i*ADDR_W +: ADDR_W];
        w_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Address/data/id only load on accept so they hold their last value when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_gid  <= '0;
    end else begin
      r_wr <= w_accept;
      if (w_accept) begin
        r_addr <= w_addr;
        r_data <= w_data;
        r_gid  <= w_win;
      end
    end
  end

  assign rf_write_n = ~r_wr;
  assign rf_addr    = r_addr;
  assign rf_data    = r_data;
  assign grant_id   = r_gid;

  always_comb begin
    rf_busy = '0;
    if (r_wr) begin
      rf_busy[r_addr] = 1'b1;
    end
  end

`ifdef RF_ARB_PERF_EN
  logic [15:0] r_conflict;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_conflict <= '0;
    end else if (!stall && ($countones(req_valid) >= 2) && (r_conflict != 16'hFFFF)) begin
      r_conflict <= r_conflict + 16'd1;
    end
  end

  assign conflict_cnt = r_conflict;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_regfile_write_arbiter                                              |
// | Directed plus random checks against a round-robin reference model.    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_regfile_write_arbiter;
  localparam int NR = 3;
  localparam int AW = 3;
  localparam int DW = 16;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    valid;
  logic [NR-1:0]    req_ready;
  logic [NR*AW-1:0] addr_bus;
  logic [NR*DW-1:0] data_bus;
  logic             stall;
  logic             rf_write_n;
  logic [AW-1:0]    rf_addr;
  logic [DW-1:0]    rf_data;
  logic [2**AW-1:0] rf_busy;
  logic [1:0]       grant_id;
`ifdef RF_ARB_PERF_EN
  logic [15:0]      conflict_cnt;
  int               m_cnt;
`endif

  logic [AW-1:0] a_addr [NR];
  logic [DW-1:0] a_data [NR];

  int            n_cmp;
  int            n_bad;
  int            m_ptr;
  bit            m_wr;
  int            m_addr;
  int            m_data;
  int            m_gid;
  logic [NR-1:0] last_acc;

  regfile_write_arbiter #(
    .NUM_REQ (NR),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) dut (
    .clk        (clk),
    .reset      (rst),
    .req_valid  (valid),
    .req_ready  (req_ready),
    .req_addr   (addr_bus),
    .req_data   (data_bus),
    .stall      (stall),
    .rf_write_n (rf_write_n),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .rf_busy    (rf_busy),
    .grant_id   (grant_id)
`ifdef RF_ARB_PERF_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      addr_bus[i*AW +: AW] = a_addr[i];
      data_bus[i*DW +: DW] = a_data[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // First valid requester at or after the pointer, modulo NR.
  function automatic logic [NR-1:0] model_ready();
    logic [NR-1:0] r;
    r = '0;
    if (rst || stall) return r;
    for (int k = 0; k < NR; k++) begin
      int idx;
      idx = (m_ptr + k) % NR;
      if (valid[idx]) begin
        r[idx] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic step(input string tag);
    logic [NR-1:0] er;
    logic [31:0]   busy;
    #1;
    er = model_ready();
    check({tag, "_ready"}, 32'(req_ready), 32'(er));
    @(posedge clk);
`ifdef RF_ARB_PERF_EN
    if (rst) m_cnt = 0;
    else if (!stall && $countones(valid) >= 2 && m_cnt < 65535) m_cnt++;
`endif
    if (rst) begin
      m_ptr = 0; m_wr = 0; m_addr = 0; m_data = 0; m_gid = 0;
    end else if (er != '0) begin
      for (int i = 0; i < NR; i++) begin
        if (er[i]) begin
          m_wr = 1; m_addr = int'(a_addr[i]); m_data = int'(a_data[i]);
          m_gid = i; m_ptr = (i + 1) % NR;
        end
      end
    end else begin
      m_wr = 0;
    end
    last_acc = er;
    #1;
    busy = m_wr ? (32'd1 << m_addr) : 32'd0;
    check({tag, "_wn"},   32'(rf_write_n), m_wr ? 32'd0 : 32'd1);
    check({tag, "_addr"}, 32'(rf_addr),    m_addr);
    check({tag, "_data"}, 32'(rf_data),    m_data);
    check({tag, "_gid"},  32'(grant_id),   m_gid);
    check({tag, "_busy"}, 32'(rf_busy),    busy);
`ifdef RF_ARB_PERF_EN
    check({tag, "_cnt"},  32'(conflict_cnt), m_cnt);
`endif
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    m_ptr = 0; m_wr = 0; m_addr = 0; m_data = 0; m_gid = 0;
    last_acc = '0;
`ifdef RF_ARB_PERF_EN
    m_cnt = 0;
`endif
    rst = 1'b1; stall = 1'b0; valid = '0;
    for (int i = 0; i < NR; i++) begin a_addr[i] = '0; a_data[i] = '0; end

    // Reset state, with live requests to confirm ready stays low under reset
    step("rst0");
    valid = 3'b111;
    step("rst1");
    check("rst_wn", 32'(rf_write_n), 32'd1);
    check("rst_addr", 32'(rf_addr), 32'd0);
    check("rst_gid", 32'(grant_id), 32'd0);
    rst = 1'b0; valid = '0;

    // Single request
    valid = 3'b001; a_addr[0] = 3'd5; a_data[0] = 16'hA5A5;
    #1 check("single_ready_const", 32'(req_ready), 32'b001);
    step("single_acc");
    valid = '0;
    check("single_wn_const", 32'(rf_write_n), 32'd0);
    check("single_busy_const", 32'(rf_busy), 32'h20);
    check("single_data_const", 32'(rf_data), 32'hA5A5);
    step("single_idle");
    check("idle_hold_data", 32'(rf_data), 32'hA5A5);

    // Contention after fresh reset: grants 0,1,2 back to back
    rst = 1'b1; step("cont_rst"); rst = 1'b0;
    valid = 3'b111;
    for (int i = 0; i < NR; i++) begin a_addr[i] = AW'(i + 1); a_data[i] = DW'(16'h1000 + i); end
    for (int k = 0; k < 3; k++) begin
      step("cont");
      check("cont_order", 32'(grant_id), k);
      check("cont_wn_const", 32'(rf_write_n), 32'd0);
    end

    // Wrap: pointer back at 0, then requester 2
    valid = 3'b101;
    step("wrap0"); check("wrap_first", 32'(grant_id), 32'd0);
    step("wrap2"); check("wrap_second", 32'(grant_id), 32'd2);
    valid = '0; step("wrap_idle");

    // Stall
    valid = 3'b010; stall = 1'b1; a_addr[1] = 3'd6; a_data[1] = 16'hBEEF;
    for (int k = 0; k < 4; k++) begin
      step("stall");
      check("stall_wn_const", 32'(rf_write_n), 32'd1);
    end
    stall = 1'b0;
    step("unstall");
    valid = '0;
    check("unstall_data", 32'(rf_data), 32'hBEEF);

    // Reset mid-op drops the registered write and clears the pointer
    valid = 3'b001; a_addr[0] = 3'd3; a_data[0] = 16'h1234;
    step("rm_acc");
    valid = 3'b011; rst = 1'b1;
    step("rm_rst");
    check("rm_wn_const", 32'(rf_write_n), 32'd1);
    rst = 1'b0;
    step("rm_after");
    check("rm_ptr_gid", 32'(grant_id), 32'd0);

    // Random traffic; unaccepted requesters hold their addr/data
    valid = '0;
    for (int n = 0; n < 400; n++) begin
      rst   = ($urandom_range(0, 39) == 0);
      stall = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < NR; i++) begin
        if (!(valid[i] && !last_acc[i])) begin
          valid[i]  = ($urandom_range(0, 2) != 0);
          a_addr[i] = AW'($urandom);
          a_data[i] = DW'($urandom);
        end
      end
      step("rand");
    end
    rst = 1'b0; stall = 1'b0;

`ifdef RF_ARB_PERF_EN
    rst = 1'b1; valid = '0; step("perf_rst"); rst = 1'b0;
    valid = 3'b011;
    for (int n = 0; n < 70000; n++) step("perf");
    check("perf_sat_const", 32'(conflict_cnt), 32'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3: number of write requesters (2..4).
REQ-002 SHALL have parameter ADDR_W, default 3: register-file address width (8 registers).
REQ-003 SHALL have parameter DATA_W, default 16: register data width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester write request.
REQ-007 SHALL have port req_ready  output  NUM_REQ  per-requester accept, at most one bit high.
REQ-008 SHALL have port req_addr  input  NUM_REQ*ADDR_W  packed target addresses, requester i at slice i.
REQ-009 SHALL have port req_data  input  NUM_REQ*DATA_W  packed write data, requester i at slice i.
REQ-010 SHALL have port stall  input  1  blocks new grants while high.
REQ-011 SHALL have port rf_write_n  output  1  active-low write strobe to the register file.
REQ-012 SHALL have port rf_addr  output  ADDR_W  register-file write address.
REQ-013 SHALL have port rf_data  output  DATA_W  register-file write data.
REQ-014 SHALL have port rf_busy  output  2**ADDR_W  one-hot of the register being written this cycle.
REQ-015 SHALL have port grant_id  output  2  index of the requester whose write is on the rf_* outputs.

Function
REQ-016 Accept = req_valid[i] & req_ready[i]. req_ready SHALL be combinational from req_valid, round-robin pointer and stall.
REQ-017 Winner SHALL be the first valid requester searching upward from the pointer, wrapping modulo NUM_REQ.
REQ-018 On accept, pointer SHALL become (winner+1) mod NUM_REQ at the next edge. Pointer unchanged when nothing is accepted.
REQ-019 Latency SHALL be one cycle. After an accept at edge N, during cycle N+1: rf_write_n=0, rf_addr/rf_data = accepted addr/data, grant_id = winner.
REQ-020 rf_write_n SHALL be 1 in every cycle not preceded by an accept. rf_addr, rf_data and grant_id SHALL hold their last values while rf_write_n=1.
REQ-021 Back-to-back accepts SHALL produce consecutive rf_write_n=0 cycles, one write per cycle, with no bubble.
REQ-022 stall=1 SHALL force req_ready=0. A write already registered SHALL still complete in the cycle of the stall.
REQ-023 rf_busy SHALL equal the one-hot of rf_addr when rf_write_n=0, and all-zero otherwise.
REQ-024 Simultaneous requests to the same address SHALL be serialised in round-robin order; the last write committed wins.
REQ-025 A requester with valid=1 and ready=0 SHALL keep its addr/data stable. The bench checks this; RTL does not latch unaccepted requests.

Reset
REQ-026 With reset=1 at an edge: pointer=0, rf_write_n=1, rf_addr=0, rf_data=0, grant_id=0, conflict counter=0.
REQ-027 While reset=1, req_ready SHALL be 0.
REQ-028 Reset mid-operation SHALL drop any registered write: rf_write_n=1 in the cycle after the reset edge.

Configuration
REQ-029 Macro RF_ARB_PERF_EN defined SHALL add output port conflict_cnt (16 bits). conflict_cnt increments when stall=0, reset=0 and at least two req_valid bits are high, saturates at 16'hFFFF, and resets to 0.
REQ-030 Without RF_ARB_PERF_EN, the conflict_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-031 Package rf_arb_pkg SHALL hold the defaults RF_ADDR_W=3, RF_DATA_W=16, RF_NUM_REQ=3 and the type rf_req_id_t (2 bits).
REQ-032 Sub-module rr_arbiter SHALL contain the pointer and the grant pick logic. The top level SHALL hold the output register, rf_busy decode and the counter.

Verification
REQ-033 Single request: after reset, valid=3'b001 with addr=5, data=16'hA5A5 for 1 cycle -> ready=001 that cycle; next cycle rf_write_n=0, rf_addr=5, rf_data=A5A5, grant_id=0, rf_busy=8'h20.
REQ-034 Contention: valid=3'b111 held for 3 cycles with distinct data -> grants in order 0,1,2; three consecutive rf_write_n=0 cycles.
REQ-035 Round-robin wrap: after requester 2 wins, valid=3'b101 -> requester 0 wins, then requester 2 wins.
REQ-036 Stall: valid=3'b010, stall=1 for 4 cycles -> ready=0 and rf_write_n=1 throughout; stall drops -> accept, and the write appears 1 cycle later.
REQ-037 Reset mid-op: accept at edge N, reset=1 at edge N+1 -> rf_write_n=1 and pointer=0 after edge N+1.
REQ-038 With RF_ARB_PERF_EN: valid=3'b011 for 70000 cycles -> conflict_cnt=16'hFFFF, held at saturation.
